// File: rtl/light_pkg.sv
// Shared definitions for the lamp brightness controller: level encoding and
// the level sequencing helper.
package light_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF  = 2'd0,
    ST_LOW  = 2'd1,
    ST_MID  = 2'd2,
    ST_HIGH = 2'd3
  } level_e;

  // Button sequence OFF -> LOW -> MID -> HIGH -> OFF.
  function automatic level_e next_level(input level_e cur);
    level_e nxt;
    case (cur)
      ST_OFF:  nxt = ST_LOW;
      ST_LOW:  nxt = ST_MID;
      ST_MID:  nxt = ST_HIGH;
      default: nxt = ST_OFF;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/light_pwm_controller_pwm_core.sv
// PWM engine: step counter advanced by ticks, shadow duty loaded at period
// wrap, and a registered compare output.
module pwm_core #(
  parameter int unsigned PWM_PERIOD = 10,
  parameter int unsigned CNT_W      = $clog2(PWM_PERIOD),
  parameter int unsigned DUTY_W     = $clog2(PWM_PERIOD + 1)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_tick,
  input  logic [DUTY_W-1:0] i_duty,
  output logic              o_pwm
);

  logic [CNT_W-1:0]  cnt_q,  cnt_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              pwm_q,  pwm_d;

  // Duty only changes on the wrap tick so every period is whole.
  always_comb begin
    cnt_d  = cnt_q;
    duty_d = duty_q;
    if (i_tick) begin
      if (cnt_q == CNT_W'(PWM_PERIOD - 1)) begin
        cnt_d  = '0;
        duty_d = i_duty;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Compare against the post-edge values so a full duty never drops at wrap.
    pwm_d = (DUTY_W'(cnt_d) < duty_d);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign o_pwm = pwm_q;

endmodule

// File: rtl/light_pwm_controller.sv
// Lamp brightness controller: synchronises the step clock and button, steps a
// four-level FSM on button presses and drives the lamp through pwm_core.
module light_pwm_controller
  import light_pkg::*;
#(
  parameter int unsigned PWM_PERIOD = 10,
  parameter int unsigned DUTY_LOW   = 2,
  parameter int unsigned DUTY_MID   = 5,
  parameter int unsigned DUTY_HIGH  = 10
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_step_clk,
  input  logic               i_btn,
  output logic               o_pwm,
  output logic [STATE_W-1:0] o_state
);

  localparam int unsigned DUTY_W = $clog2(PWM_PERIOD + 1);

  if (PWM_PERIOD < 2 || DUTY_LOW > PWM_PERIOD || DUTY_MID > PWM_PERIOD ||
      DUTY_HIGH > PWM_PERIOD) begin : g_param_err
    $error("light_pwm_controller: illegal PWM_PERIOD/DUTY_* combination");
  end

  logic [1:0] step_sync_q, step_sync_d;
  logic [1:0] btn_sync_q,  btn_sync_d;
  logic       step_hist_q, step_hist_d;
  logic       btn_hist_q,  btn_hist_d;
  level_e     state_q,     state_d;
  logic       step_tick_c;
  logic       btn_press_c;
  logic [DUTY_W-1:0] duty_c;

  // Two-flop synchronisers followed by rising-edge history flops.
  always_comb begin
    step_sync_d = {step_sync_q[0], i_step_clk};
    btn_sync_d  = {btn_sync_q[0], i_btn};
    step_hist_d = step_sync_q[1];
    btn_hist_d  = btn_sync_q[1];
    step_tick_c = step_sync_q[1] & ~step_hist_q;
    btn_press_c = btn_sync_q[1] & ~btn_hist_q;
  end

  always_comb begin
    state_d = state_q;
    if (btn_press_c) begin
      state_d = next_level(state_q);
    end
  end

  // Duty follows the registered level; pwm_core only samples it at wrap.
  always_comb begin
    duty_c = '0;
    case (state_q)
      ST_LOW:  duty_c = DUTY_W'(DUTY_LOW);
      ST_MID:  duty_c = DUTY_W'(DUTY_MID);
      ST_HIGH: duty_c = DUTY_W'(DUTY_HIGH);
      default: duty_c = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      step_sync_q <= '0;
      btn_sync_q  <= '0;
      step_hist_q <= 1'b0;
      btn_hist_q  <= 1'b0;
      state_q     <= ST_OFF;
    end else begin
      step_sync_q <= step_sync_d;
      btn_sync_q  <= btn_sync_d;
      step_hist_q <= step_hist_d;
      btn_hist_q  <= btn_hist_d;
      state_q     <= state_d;
    end
  end

  pwm_core #(
    .PWM_PERIOD (PWM_PERIOD)
  ) u_pwm_core (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_tick  (step_tick_c),
    .i_duty  (duty_c),
    .o_pwm   (o_pwm)
  );

  assign o_state = state_q;

endmodule

// File: tb/tb_light_pwm_controller.sv
// Bench for light_pwm_controller: directed scenarios plus random button
// activity, checked every cycle against a step/period level model.
module tb_light_pwm_controller;

  localparam int PERIOD   = 10;
  localparam int STEP_CYC = 20;
  localparam int PER_CYC  = PERIOD * STEP_CYC;

  logic       i_clk;
  logic       i_reset;
  logic       i_step_clk;
  logic       i_btn;
  logic       o_pwm;
  logic [1:0] o_state;

  int errors = 0;
  int checks = 0;
  bit step_run;

  int m_level = 0;
  int m_pos   = 0;
  int m_duty  = 0;
  int m_wraps = 0;
  bit bh[4];
  bit sh[4];

  light_pwm_controller dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_step_clk (i_step_clk),
    .i_btn      (i_btn),
    .o_pwm      (o_pwm),
    .o_state    (o_state)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Step clock: toggles every 10 i_clk cycles on the falling edge while enabled.
  initial begin
    int sc;
    sc = 0;
    i_step_clk = 1'b0;
    forever begin
      @(negedge i_clk);
      if (step_run) begin
        sc++;
        if (sc == STEP_CYC / 2) begin
          sc = 0;
          i_step_clk = ~i_step_clk;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int duty_of(input int lvl);
    case (lvl)
      1:       return 2;
      2:       return 5;
      3:       return 10;
      default: return 0;
    endcase
  endfunction

  // Reference model: an input rise becomes visible 3 edges after it is first sampled.
  always begin
    bit bs, ss, rs, press, tick;
    @(posedge i_clk);
    bs = i_btn;
    ss = i_step_clk;
    rs = i_reset;
    #1;
    if (rs) begin
      m_level = 0;
      m_pos   = 0;
      m_duty  = 0;
      for (int i = 0; i < 4; i++) begin
        bh[i] = 1'b0;
        sh[i] = 1'b0;
      end
    end else begin
      for (int i = 3; i > 0; i--) begin
        bh[i] = bh[i-1];
        sh[i] = sh[i-1];
      end
      bh[0] = bs;
      sh[0] = ss;
      press = bh[2] && !bh[3];
      tick  = sh[2] && !sh[3];
      if (tick) begin
        if (m_pos == PERIOD - 1) begin
          m_duty = duty_of(m_level);
          m_wraps++;
        end
        m_pos = (m_pos + 1) % PERIOD;
      end
      if (press) m_level = (m_level + 1) % 4;
    end
    chk("model_state", 32'(o_state), 32'(m_level));
    chk("model_pwm", 32'(o_pwm), 32'(m_pos < m_duty));
  end

  task automatic tick_clk();
    @(posedge i_clk);
    #2;
  endtask

  task automatic count_high(input int n, output int c);
    c = int'(o_pwm);
    repeat (n - 1) begin
      tick_clk();
      c += int'(o_pwm);
    end
  endtask

  task automatic wait_wrap();
    int w;
    int n;
    w = m_wraps;
    n = 0;
    while (m_wraps == w && n < 3 * PER_CYC) begin
      tick_clk();
      n++;
    end
    chk("wrap_seen", 32'(m_wraps != w), 32'd1);
  endtask

  task automatic press();
    i_btn = 1'b1;
    repeat (5) tick_clk();
    i_btn = 1'b0;
    repeat (3) tick_clk();
  endtask

  initial begin
    int c;
    int n;
    int s0;
    logic p0;
    i_reset  = 1'b1;
    i_btn    = 1'b0;
    step_run = 1'b1;
    #1;
    chk("reset_pwm", 32'(o_pwm), 32'd0);
    chk("reset_state", 32'(o_state), 32'd0);
    repeat (3) tick_clk();
    i_reset = 1'b0;

    // Idle for three periods: lamp off.
    count_high(3 * PER_CYC, c);
    chk("idle_high_count", 32'(c), 32'd0);
    chk("idle_state", 32'(o_state), 32'd0);

    // Single press: state changes on the third sampling edge.
    i_btn = 1'b1;
    tick_clk();
    chk("btn_edge1", 32'(o_state), 32'd0);
    tick_clk();
    chk("btn_edge2", 32'(o_state), 32'd0);
    tick_clk();
    chk("btn_edge3", 32'(o_state), 32'd1);
    repeat (3) tick_clk();
    i_btn = 1'b0;
    wait_wrap();
    count_high(PER_CYC, c);
    chk("low_high_count", 32'(c), 32'd2 * STEP_CYC);

    // Press coincident with the wrap tick while in LOW.
    n = 0;
    while (m_pos != PERIOD - 1 && n < 2 * PER_CYC) begin
      tick_clk();
      n++;
    end
    chk("pos9_seen", 32'(m_pos), 32'(PERIOD - 1));
    @(posedge i_step_clk);
    i_btn = 1'b1;
    repeat (3) tick_clk();
    chk("coincide_state", 32'(o_state), 32'd2);
    count_high(PER_CYC, c);
    chk("coincide_old_duty", 32'(c), 32'd2 * STEP_CYC);
    tick_clk();
    count_high(PER_CYC, c);
    chk("coincide_new_duty", 32'(c), 32'd5 * STEP_CYC);
    i_btn = 1'b0;
    repeat (3) tick_clk();

    // HIGH is constantly on, including across the wrap.
    press();
    chk("high_state", 32'(o_state), 32'd3);
    wait_wrap();
    count_high(PER_CYC, c);
    chk("high_period", 32'(c), 32'(PER_CYC));
    repeat (100) tick_clk();
    count_high(PER_CYC, c);
    chk("high_across_wrap", 32'(c), 32'(PER_CYC));
    press();
    chk("wrap_to_off", 32'(o_state), 32'd0);
    wait_wrap();
    count_high(PER_CYC, c);
    chk("off_after_high", 32'(c), 32'd0);

    // Asynchronous reset mid-period in MID with the lamp on.
    press();
    press();
    chk("mid_state", 32'(o_state), 32'd2);
    wait_wrap();
    repeat (30) tick_clk();
    chk("mid_pwm_on", 32'(o_pwm), 32'd1);
    i_reset = 1'b1;
    #1;
    chk("async_rst_pwm", 32'(o_pwm), 32'd0);
    chk("async_rst_state", 32'(o_state), 32'd0);
    repeat (3) tick_clk();
    i_reset = 1'b0;
    wait_wrap();
    count_high(PER_CYC, c);
    chk("post_rst_off", 32'(c), 32'd0);
    press();
    chk("post_rst_press", 32'(o_state), 32'd1);

    // Random button activity, checked by the model every cycle.
    repeat (8) begin
      repeat ($urandom_range(3, 250)) tick_clk();
      i_btn = 1'b1;
      repeat ($urandom_range(2, 40)) tick_clk();
      i_btn = 1'b0;
      repeat (3) tick_clk();
    end

    // Long hold with a frozen step clock: one advance, output frozen.
    step_run = 1'b0;
    repeat (5) tick_clk();
    p0 = o_pwm;
    s0 = int'(o_state);
    i_btn = 1'b1;
    repeat (100) begin
      tick_clk();
      chk("frozen_pwm", 32'(o_pwm), 32'(p0));
    end
    chk("hold_one_advance", 32'(o_state), 32'((s0 + 1) % 4));
    i_btn = 1'b0;
    repeat (5) tick_clk();
    step_run = 1'b1;
    repeat (50) tick_clk();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
